// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch
// port (i_*) and the load/store port (d_*), using round-robin arbitration.
// Each winning command is registered onto the mem_* bus and held there until
// mem_ack arrives or the watchdog aborts the access.
//
// Ports:
//   clk, reset                              clock, synchronous active-high reset
//   i_req, i_addr                           fetch command (held until i_gnt)
//   i_gnt, i_rvalid, i_rdata, i_err         fetch grant / completion
//   d_req, d_we, d_addr, d_wdata, d_wstrb   load/store command (held until d_gnt)
//   d_gnt, d_rvalid, d_rdata, d_err         load/store grant / completion
//   mem_req, mem_we, mem_addr, mem_wdata,
//   mem_wstrb                               registered memory command
//   mem_ack, mem_rdata                      memory completion and read data
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // The counter only has to reach TIMEOUT-1.
    localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t          state;
    logic            last_gnt_d;   // 1: the most recent grant went to the data port
    logic [WD_W-1:0] wd_cnt;
    logic            pick_d;
    logic            wd_expire;

    // Data wins when it is the only requester, or when both request and fetch won last.
    assign pick_d    = d_req && (!i_req || !last_gnt_d);
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT - 1)) && !mem_ack;

    // Arbitration FSM with registered command bus and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_gnt_d <= 1'b1;
            wd_cnt     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            i_gnt      <= 1'b0;
            i_rvalid   <= 1'b0;
            i_rdata    <= '0;
            i_err      <= 1'b0;
            d_gnt      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        mem_req <= 1'b1;
                        wd_cnt  <= '0;
                        if (pick_d) begin
                            state      <= BUSY_D;
                            d_gnt      <= 1'b1;
                            last_gnt_d <= 1'b1;
                            mem_we     <= d_we;
                            mem_addr   <= d_addr;
                            mem_wdata  <= d_wdata;
                            mem_wstrb  <= d_we ? d_wstrb : 4'b0000;
                        end else begin
                            state      <= BUSY_I;
                            i_gnt      <= 1'b1;
                            last_gnt_d <= 1'b0;
                            mem_we     <= 1'b0;
                            mem_addr   <= i_addr;
                            mem_wdata  <= '0;
                            mem_wstrb  <= 4'b0000;
                        end
                    end
                end

                BUSY_I, BUSY_D: begin
                    // An ack in the expiry cycle completes normally.
                    if (mem_ack || wd_expire) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                        if (state == BUSY_D) begin
                            d_rvalid <= 1'b1;
                            d_err    <= !mem_ack;
                            d_rdata  <= mem_ack ? mem_rdata : 32'h0;
                        end else begin
                            i_rvalid <= 1'b1;
                            i_err    <= !mem_ack;
                            i_rdata  <= mem_ack ? mem_rdata : 32'h0;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
